// File: rtl/vpu_wb_burst_unit.sv
// Write-back burst unit: gathers lane results into SRAM lines through a
// two-entry ping-pong buffer and issues one line write per completed line.
module vpu_wb_burst_unit #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned LANE_W    = 32,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BANK_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [$clog2(BURST_MAX):0] burst_len_i,
  input  logic [ADDR_W-1:0]          waddr_i,
  input  logic                       bcast_i,
  output logic                       busy_o,
  output logic                       done_o,
  input  logic                       wb_valid_i,
  output logic                       wb_ready_o,
  input  logic [LANE_W-1:0]          wb_data_i,
  output logic                       dst_req_o,
  input  logic                       dst_ack_i,
  output logic                       dst_web_o,
  output logic [BANK_W-1:0]          dst_wid_o,
  output logic [ADDR_W-BANK_W-1:0]   dst_addr_o,
  output logic                       dst_wlast_o,
  output logic [LANES*LANE_W-1:0]    dst_wdata_o
);

  localparam int unsigned LINE_W = LANES * LANE_W;
  localparam int unsigned LEN_W  = $clog2(BURST_MAX) + 1;
  localparam int unsigned LA_W   = ADDR_W - BANK_W;
  localparam int unsigned LC_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LC_W-1:0] LAST_LANE = LC_W'(LANES - 1);

  typedef enum logic [1:0] {StIdle, StActive, StFinish} state_e;

  state_e             r_state, w_state_nxt;
  logic [LEN_W-1:0]   r_len;
  logic [LA_W-1:0]    r_base;
  logic [BANK_W-1:0]  r_wid;
  logic               r_bcast;
  logic [LC_W-1:0]    r_lane_cnt;
  logic [LEN_W-1:0]   r_fill_cnt;
  logic [LEN_W-1:0]   r_wr_cnt;
  logic [1:0]         r_full_cnt;
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [LINE_W-1:0]  r_buf [2];

  logic               w_start;
  logic               w_accept;
  logic               w_line_done;
  logic               w_wr_fire;
  logic               w_last_wr;
  logic [LEN_W-1:0]   w_len_in;
  logic [LINE_W-1:0]  w_fill_line;

  assign w_start     = (r_state == StIdle) && start_i;
  assign w_len_in    = (burst_len_i == '0) ? LEN_W'(1) : burst_len_i;
  assign w_accept    = wb_valid_i && wb_ready_o;
  assign w_line_done = w_accept && (r_bcast || (r_lane_cnt == LAST_LANE));
  assign w_wr_fire   = dst_req_o && dst_ack_i;
  assign w_last_wr   = (r_wr_cnt == (r_len - LEN_W'(1)));

  // A filling slot exists only while fewer than two complete lines are held.
  assign wb_ready_o  = (r_state == StActive) && (r_full_cnt != 2'd2) && (r_fill_cnt < r_len);
  assign dst_req_o   = (r_state == StActive) && (r_full_cnt != 2'd0);
  assign dst_web_o   = ~dst_req_o;
  assign dst_wid_o   = r_wid;
  assign dst_addr_o  = r_base + LA_W'(r_wr_cnt);
  assign dst_wlast_o = dst_req_o && w_last_wr;
  assign dst_wdata_o = r_buf[r_rd_ptr];
  assign busy_o      = (r_state == StActive);
  assign done_o      = (r_state == StFinish);

  always_comb begin
    w_fill_line = r_buf[r_wr_ptr];
    for (int unsigned i = 0; i < LANES; i++) begin
      if (r_bcast || (r_lane_cnt == LC_W'(i))) begin
        w_fill_line[i*LANE_W +: LANE_W] = wb_data_i;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (start_i) w_state_nxt = StActive;
      StActive: if (w_wr_fire && w_last_wr) w_state_nxt = StFinish;
      StFinish: w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_len      <= '0;
      r_base     <= '0;
      r_wid      <= '0;
      r_bcast    <= 1'b0;
      r_lane_cnt <= '0;
      r_fill_cnt <= '0;
      r_wr_cnt   <= '0;
      r_full_cnt <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      for (int i = 0; i < 2; i++) r_buf[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_len      <= w_len_in;
        r_base     <= waddr_i[ADDR_W-1:BANK_W];
        r_wid      <= waddr_i[BANK_W-1:0];
        r_bcast    <= bcast_i;
        r_lane_cnt <= '0;
        r_fill_cnt <= '0;
        r_wr_cnt   <= '0;
        r_full_cnt <= 2'd0;
        r_wr_ptr   <= 1'b0;
        r_rd_ptr   <= 1'b0;
      end else if (r_state == StActive) begin
        if (w_accept) begin
          r_buf[r_wr_ptr] <= w_fill_line;
          r_lane_cnt      <= w_line_done ? '0 : r_lane_cnt + LC_W'(1);
          if (w_line_done) begin
            r_fill_cnt <= r_fill_cnt + LEN_W'(1);
            r_wr_ptr   <= ~r_wr_ptr;
          end
        end
        if (w_wr_fire) begin
          r_rd_ptr <= ~r_rd_ptr;
          r_wr_cnt <= r_wr_cnt + LEN_W'(1);
        end
        // Completion and ack in the same cycle leave the held-line count unchanged.
        unique case ({w_line_done, w_wr_fire})
          2'b10:   r_full_cnt <= r_full_cnt + 2'd1;
          2'b01:   r_full_cnt <= r_full_cnt - 2'd1;
          default: r_full_cnt <= r_full_cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vpu_wb_burst_unit.sv
// Scoreboard bench for vpu_wb_burst_unit: directed bursts push expected line
// writes; a negedge monitor pops and compares each accepted write.
module tb_vpu_wb_burst_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [2:0]   burst_len_i;
  logic [15:0]  waddr_i;
  logic         bcast_i;
  logic         busy_o, done_o;
  logic         wb_valid_i, wb_ready_o;
  logic [31:0]  wb_data_i;
  logic         dst_req_o, dst_ack_i, dst_web_o, dst_wlast_o;
  logic [1:0]   dst_wid_o;
  logic [13:0]  dst_addr_o;
  logic [127:0] dst_wdata_o;
  logic         ack_hold;

  typedef struct packed {
    logic [1:0]   wid;
    logic [13:0]  addr;
    logic         wlast;
    logic [127:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  n_done = 0;
  int  exp_done = 0;

  assign dst_ack_i = ~ack_hold;

  always #5 clk = ~clk;

  vpu_wb_burst_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .burst_len_i (burst_len_i),
    .waddr_i     (waddr_i),
    .bcast_i     (bcast_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .wb_valid_i  (wb_valid_i),
    .wb_ready_o  (wb_ready_o),
    .wb_data_i   (wb_data_i),
    .dst_req_o   (dst_req_o),
    .dst_ack_i   (dst_ack_i),
    .dst_web_o   (dst_web_o),
    .dst_wid_o   (dst_wid_o),
    .dst_addr_o  (dst_addr_o),
    .dst_wlast_o (dst_wlast_o),
    .dst_wdata_o (dst_wdata_o)
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_line(input logic [31:0] b0, input logic [31:0] b1,
                                           input logic [31:0] b2, input logic [31:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic push(input logic [1:0] wid, input logic [13:0] addr, input logic wlast,
                      input logic [127:0] data);
    wr_t e;
    e.wid = wid; e.addr = addr; e.wlast = wlast; e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every write handshake, payload stability and done timing.
  wr_t cur, held, ev;
  logic prev_hold = 1'b0;
  logic prev_last = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
      prev_last = 1'b0;
    end else begin
      cur = {dst_wid_o, dst_addr_o, dst_wlast_o, dst_wdata_o};
      if (prev_last) chk("done_after_last_ack", done_o, 1'b1);
      if (done_o) n_done++;
      if (dst_req_o && prev_hold) chk("payload_stable", cur, held);
      if (dst_req_o && dst_ack_i) begin
        chk("web_low_on_write", dst_web_o, 1'b0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1'b1, 1'b0);
        end else begin
          ev = exp_q.pop_front();
          chk("write_payload", cur, ev);
        end
      end
      prev_hold = dst_req_o && !dst_ack_i;
      held      = cur;
      prev_last = dst_req_o && dst_ack_i && dst_wlast_o;
    end
  end

  task automatic start(input logic [2:0] len, input logic [15:0] addr, input logic b);
    start_i = 1'b1; burst_len_i = len; waddr_i = addr; bcast_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1'b1);
  endtask

  task automatic send_beat(input logic [31:0] d);
    int t = 0;
    wb_valid_i = 1'b1; wb_data_i = d;
    while (!wb_ready_o && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) chk("beat_accept_timeout", 1'b0, 1'b1);
    else begin
      @(posedge clk); #1;
    end
    wb_valid_i = 1'b0;
  endtask

  task automatic send4(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                       input logic [31:0] b3);
    send_beat(b0); send_beat(b1); send_beat(b2); send_beat(b3);
  endtask

  task automatic wait_q_empty();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) chk("write_drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    int t = 0;
    wait_q_empty();
    while (busy_o && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) chk("busy_drop_timeout", 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("done_count", n_done, exp_done);
    chk("idle_not_busy", busy_o, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_req"}, dst_req_o, 1'b0);
    chk({tag, "_web"}, dst_web_o, 1'b1);
    chk({tag, "_wlast"}, dst_wlast_o, 1'b0);
    chk({tag, "_ready"}, wb_ready_o, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; burst_len_i = '0; waddr_i = '0; bcast_i = 1'b0;
    wb_valid_i = 1'b0; wb_data_i = '0; ack_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // Single line, immediate ack.
    push(2'd2, 14'd1, 1'b1, 128'h00000044_00000033_00000022_00000011);
    exp_done++;
    start(3'd1, 16'h0006, 1'b0);
    send4(32'h11, 32'h22, 32'h33, 32'h44);
    drain();

    // Broadcast, two lines.
    push(2'd0, 14'd4, 1'b0, {4{32'hA5}});
    push(2'd0, 14'd5, 1'b1, {4{32'h5A}});
    exp_done++;
    start(3'd2, 16'h0010, 1'b1);
    send_beat(32'hA5);
    send_beat(32'h5A);
    drain();

    // Four lines with ack held off: buffer fills to two lines and stalls.
    for (int l = 0; l < 4; l++)
      push(2'd1, 14'(8 + l), (l == 3), mk_line(32'h100 + 4*l, 32'h101 + 4*l,
                                                32'h102 + 4*l, 32'h103 + 4*l));
    exp_done++;
    ack_hold = 1'b1;
    start(3'd4, 16'h0021, 1'b0);
    for (int j = 0; j < 8; j++) send_beat(32'h100 + j);
    chk("ready_low_two_lines_held", wb_ready_o, 1'b0);
    chk("req_high_while_held", dst_req_o, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("ready_still_low", wb_ready_o, 1'b0);
    chk("no_write_while_held", exp_q.size(), 4);
    ack_hold = 1'b0;
    for (int j = 8; j < 16; j++) send_beat(32'h100 + j);
    drain();

    // Zero length treated as one.
    push(2'd3, 14'd1, 1'b1, mk_line(32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003));
    exp_done++;
    start(3'd0, 16'h0007, 1'b0);
    send4(32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003);
    drain();

    // Reset after three of four lines: no fourth write, no done.
    for (int l = 0; l < 3; l++)
      push(2'd0, 14'(l), 1'b0, mk_line(32'h200 + 4*l, 32'h201 + 4*l,
                                       32'h202 + 4*l, 32'h203 + 4*l));
    start(3'd4, 16'h0000, 1'b0);
    for (int j = 0; j < 12; j++) send_beat(32'h200 + j);
    wait_q_empty();
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("midrst");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_after_abort", n_done, exp_done);
    push(2'd1, 14'd1, 1'b1, {4{32'hCAFE0001}});
    exp_done++;
    start(3'd1, 16'h0005, 1'b1);
    send_beat(32'hCAFE0001);
    drain();

    // Start pulsed while busy is ignored.
    push(2'd2, 14'h10, 1'b0, mk_line(32'h300, 32'h301, 32'h302, 32'h303));
    push(2'd2, 14'h11, 1'b1, mk_line(32'h304, 32'h305, 32'h306, 32'h307));
    exp_done++;
    start(3'd2, 16'h0042, 1'b0);
    send_beat(32'h300);
    start_i = 1'b1; burst_len_i = 3'd1; waddr_i = 16'h0100; bcast_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; bcast_i = 1'b0;
    chk("busy_kept_on_restart", busy_o, 1'b1);
    for (int j = 1; j < 8; j++) send_beat(32'h300 + j);
    drain();
    chk("queue_empty_at_end", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
